axil_lite_master: RTL and testbench
===================================

# axil_lite_master

AXI-Lite initiator that turns a single-outstanding CPU-side memory request port into AXI4-Lite read and write transactions. It sits between the core's load/store unit and AXI-Lite responders such as the BRAM memory and peripheral slaves. It performs one transaction at a time, with no reordering and no pipelining across requests.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width on both sides
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with AXIL_MASTER_TIMEOUT_EN)

Ports:
- aclk  in  1  clock; all logic is on the rising edge
- areset  in  1  reset; one clock, asynchronous, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address, forwarded unmodified
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  STRB_WIDTH  byte enables; ignored on reads
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  read data; holds its value until the next read completes
- resp_err  out  1  response was SLVERR/DECERR, or a timeout occurred
- m_axil_aw*: awaddr, awprot, awvalid (out); awready (in)
- m_axil_w*: wdata, wstrb, wvalid (out); wready (in)
- m_axil_b*: bresp[1:0], bvalid (in); bready (out)
- m_axil_ar*: araddr, arprot, arvalid (out); arready (in)
- m_axil_r*: rdata, rresp[1:0], rvalid (in); rready (out)

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - Latch addr, wdata and wstrb.
  - Go to WR_ADDR_DATA (write) or RD_ADDR (read).
- WR_ADDR_DATA:
  - awvalid and wvalid are raised together.
  - Each is dropped independently on its own handshake.
  - When both handshakes are done (either order, or the same cycle), go to WR_RESP.
- WR_RESP: bready=1. On bvalid, go to IDLE. resp_err = bresp[1].
- RD_ADDR: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata into resp_rdata, set resp_err = rresp[1], go to IDLE.
- awprot and arprot are constant 3'b000.
- A valid, once raised, is never lowered before its handshake (timeout is the only exception).
- No address alignment checks. Low address bits pass through to the slave.

## Timing
- Reset values:
  - req_ready=1.
  - All m_axil valids, bready and rready = 0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - awaddr, araddr, wdata and wstrb = 0.
  - State is IDLE.
- Every output is registered.
- Request accepted in cycle N:
  - awvalid/wvalid or arvalid go high in cycle N+1.
  - bready or rready go high in the cycle after the address (and, for writes, data) handshakes complete.
- B/R handshake in cycle M:
  - resp_valid=1 in cycle M+1.
  - req_ready=1 in cycle M+1, so a new request can be accepted that same cycle.
- Minimum latency against an always-ready responder with a one-cycle response: 4 cycles from request to resp_valid.
- req_* inputs are sampled only at acceptance. Later changes are ignored.
- Reset mid-transaction: all valids and readies drop immediately and the transaction is abandoned. No resp_valid is produced for it.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to any non-IDLE state and increments every cycle outside IDLE.
  - When it reaches TIMEOUT_CYCLES: drop every valid and ready, go to IDLE, pulse resp_valid with resp_err=1, leave resp_rdata unchanged.
  - This is a deliberate protocol violation, kept for debug of hung slaves.
- Macro undefined: no counter. The block waits indefinitely and TIMEOUT_CYCLES is ignored.

## Structure
- Package axil_pkg holds:
  - axil_master_state_t enum.
  - Response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - PROT_DEFAULT=3'b000.
- One sub-module, axil_watchdog: counter plus expiry flag, instantiated only under AXIL_MASTER_TIMEOUT_EN.

## Test plan
- Write addr=0x100, wdata=0xDEADBEEF, wstrb=4'hF, always-ready slave, bresp=0 -> awaddr=0x100 and wdata=0xDEADBEEF seen on one cycle; resp_valid 4 cycles after acceptance; resp_err=0.
- Read addr=0x100 after the write above -> araddr=0x100; resp_rdata=0xDEADBEEF; resp_err=0.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held steady 3 cycles; exactly one B handshake.
- rvalid held off 5 cycles and rresp=2'b10 -> rready held until rvalid; resp_err=1.
- areset asserted while in RD_DATA -> rready=0 asynchronously; no resp_valid; the next request is accepted normally.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never raises arready -> arvalid drops after 16 cycles; resp_valid=1 with resp_err=1; req_ready returns to 1.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and AXI-Lite constants for the axil_lite_master initiator.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } axil_master_state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_lite_master_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with initiator and responder views.
interface axil_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

endinterface

// File: rtl/axil_watchdog.sv
// Counts cycles spent in the current non-IDLE state of axil_lite_master and flags expiry.
module axil_watchdog
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               aclk,
    input  logic               areset,
    input  axil_master_state_t state,
    output logic               expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    axil_master_state_t prev_state;
    logic [CW-1:0]      count;
    logic [CW-1:0]      elapsed;

    // A state change restarts the count, so elapsed is zero in a state's first cycle.
    assign elapsed = (state != prev_state) ? '0 : count;
    assign expired = (state != IDLE) && (elapsed == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            prev_state <= IDLE;
            count      <= '0;
        end else begin
            prev_state <= state;
            count      <= (state == IDLE) ? '0 : elapsed + 1'b1;
        end
    end

endmodule

// File: rtl/axil_lite_master.sv
// AXI4-Lite initiator: one CPU request at a time becomes one AXI-Lite read or write.
// Define AXIL_MASTER_TIMEOUT_EN to abort transactions whose slave stalls for TIMEOUT_CYCLES.
module axil_lite_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    axil_lite_master_if.master    m_axil
);
    axil_master_state_t state;
    logic               aw_done;
    logic               w_done;

    assign m_axil.awprot = PROT_DEFAULT;
    assign m_axil.arprot = PROT_DEFAULT;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !m_axil.awvalid || m_axil.awready;
    assign w_done  = !m_axil.wvalid  || m_axil.wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic wd_expired;

    axil_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .aclk    (aclk),
        .areset  (areset),
        .state   (state),
        .expired (wd_expired)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the later timeout block overrides earlier assignments in the same edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            m_axil.awaddr  <= '0;
            m_axil.awvalid <= 1'b0;
            m_axil.wdata   <= '0;
            m_axil.wstrb   <= '0;
            m_axil.wvalid  <= 1'b0;
            m_axil.bready  <= 1'b0;
            m_axil.araddr  <= '0;
            m_axil.arvalid <= 1'b0;
            m_axil.rready  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_write) begin
                            m_axil.awaddr  <= req_addr;
                            m_axil.wdata   <= req_wdata;
                            m_axil.wstrb   <= req_wstrb;
                            m_axil.awvalid <= 1'b1;
                            m_axil.wvalid  <= 1'b1;
                            state          <= WR_ADDR_DATA;
                        end else begin
                            m_axil.araddr  <= req_addr;
                            m_axil.arvalid <= 1'b1;
                            state          <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR_DATA: begin
                    if (m_axil.awready) m_axil.awvalid <= 1'b0;
                    if (m_axil.wready)  m_axil.wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axil.bready <= 1'b1;
                        state         <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (m_axil.bvalid) begin
                        m_axil.bready <= 1'b0;
                        resp_valid    <= 1'b1;
                        resp_err      <= resp_is_error(m_axil.bresp);
                        req_ready     <= 1'b1;
                        state         <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (m_axil.arready) begin
                        m_axil.arvalid <= 1'b0;
                        m_axil.rready  <= 1'b1;
                        state          <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (m_axil.rvalid) begin
                        m_axil.rready <= 1'b0;
                        resp_rdata    <= m_axil.rdata;
                        resp_valid    <= 1'b1;
                        resp_err      <= resp_is_error(m_axil.rresp);
                        req_ready     <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
            // Abandon a hung transaction: valids drop without a handshake on purpose.
            if (wd_expired) begin
                m_axil.awvalid <= 1'b0;
                m_axil.wvalid  <= 1'b0;
                m_axil.bready  <= 1'b0;
                m_axil.arvalid <= 1'b0;
                m_axil.rready  <= 1'b0;
                resp_valid     <= 1'b1;
                resp_err       <= 1'b1;
                req_ready      <= 1'b1;
                state          <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axil_lite_master.sv
// Self-checking bench for axil_lite_master: table of directed transactions against a
// small responder model, plus reset-mid-read and (with AXIL_MASTER_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
module tb_axil_lite_master;
    import axil_pkg::*;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int TO_CYCLES = 16;
`else
    localparam int TO_CYCLES = 1024;
`endif

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    axil_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_lite_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .STRB_WIDTH     (4),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m_axil     (bus.master)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Responder memory: one word per byte address key, missing keys read as zero.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        return mem.exists(addr) ? mem[addr] : 32'h0;
    endfunction

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] word;
        word = mem_read(addr);
        for (int b = 0; b < 4; b++)
            if (strb[b]) word[b*8 +: 8] = data[b*8 +: 8];
        mem[addr] = word;
    endtask

    // addr_wait/w_wait: cycles a valid is held before the slave grants ready.
    // resp_hold: cycles bready/rready stay high before the slave raises bvalid/rvalid.
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          addr_wait;
        int          w_wait;
        int          resp_hold;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    task automatic run_txn(input vec_t v, input string tag);
        int          aw_cnt = 0;
        int          w_cnt  = 0;
        int          ar_cnt = 0;
        int          rdy_cnt = 0;
        int          hs_cnt = 0;
        int          lat    = 0;
        int          viol   = 0;
        bit          aw_done = 0;
        bit          w_done  = 0;
        bit          ar_done = 0;
        logic [31:0] cap_addr = '0;
        logic [31:0] cap_data = '0;
        logic [3:0]  cap_strb = '0;

        check({tag, "_req_ready_idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;

        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge aclk);
            #1;
            if (cyc == 1) begin
                req_valid = 1'b0;
                req_write = ~v.write;
                req_addr  = ~v.addr;
                req_wdata = ~v.wdata;
                req_wstrb = ~v.wstrb;
            end
            bus.awready = 1'b0;
            bus.wready  = 1'b0;
            bus.arready = 1'b0;
            bus.bvalid  = 1'b0;
            bus.rvalid  = 1'b0;
            bus.rdata   = 32'h5A5A_5A5A;
            if (resp_valid) begin
                lat = cyc;
                break;
            end
            if (bus.awprot !== 3'b000 || bus.arprot !== 3'b000) viol++;
            if (bus.bready) begin
                if (!(aw_done && w_done)) viol++;
                rdy_cnt++;
                if (rdy_cnt > v.resp_hold) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = v.resp;
                    hs_cnt++;
                    mem_write(cap_addr, cap_data, cap_strb);
                end
            end
            if (bus.rready) begin
                if (!ar_done) viol++;
                rdy_cnt++;
                if (rdy_cnt > v.resp_hold) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = mem_read(cap_addr);
                    bus.rresp  = v.resp;
                    hs_cnt++;
                end
            end
            if (bus.awvalid) begin
                if (aw_done) viol++;
                aw_cnt++;
                if (aw_cnt > v.addr_wait) begin
                    bus.awready = 1'b1;
                    aw_done     = 1'b1;
                    cap_addr    = bus.awaddr;
                end
            end
            if (bus.wvalid) begin
                if (w_done) viol++;
                w_cnt++;
                if (w_cnt > v.w_wait) begin
                    bus.wready = 1'b1;
                    w_done     = 1'b1;
                    cap_data   = bus.wdata;
                    cap_strb   = bus.wstrb;
                end
            end
            if (bus.arvalid) begin
                if (ar_done) viol++;
                ar_cnt++;
                if (ar_cnt > v.addr_wait) begin
                    bus.arready = 1'b1;
                    ar_done     = 1'b1;
                    cap_addr    = bus.araddr;
                end
            end
        end

        check({tag, "_latency"},        lat,       v.exp_lat);
        check({tag, "_resp_err"},       resp_err,  v.exp_err);
        check({tag, "_resp_rdata"},     resp_rdata, v.exp_rdata);
        check({tag, "_req_ready_done"}, req_ready, 1);
        check({tag, "_handshakes"},     hs_cnt,    1);
        check({tag, "_ready_cycles"},   rdy_cnt,   v.resp_hold + 1);
        check({tag, "_addr"},           cap_addr,  v.addr);
        check({tag, "_protocol"},       viol,      0);
        if (v.write) begin
            check({tag, "_awvalid_cycles"}, aw_cnt,   v.addr_wait + 1);
            check({tag, "_wvalid_cycles"},  w_cnt,    v.w_wait + 1);
            check({tag, "_wdata"},          cap_data, v.wdata);
            check({tag, "_wstrb"},          cap_strb, v.wstrb);
            check({tag, "_arvalid_cycles"}, ar_cnt,   0);
        end else begin
            check({tag, "_arvalid_cycles"}, ar_cnt,         v.addr_wait + 1);
            check({tag, "_aw_w_cycles"},    aw_cnt + w_cnt, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int pulses;
        int ar_hi;
        int done_cyc;

        // write,  addr,        wdata,        wstrb, aw/ar, w, hold, resp,        exp_rdata,    err, lat
        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, RESP_OKAY,   32'h0000_0000, 1'b0, 4};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 0, 0, 1, RESP_OKAY,   32'hDEAD_BEEF, 1'b0, 4};
        vecs[2]  = '{1'b1, 32'h0000_0104, 32'h1122_3344, 4'h5, 3, 0, 1, RESP_OKAY,   32'hDEAD_BEEF, 1'b0, 7};
        vecs[3]  = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 0, 0, 1, RESP_OKAY,   32'h0022_0044, 1'b0, 4};
        vecs[4]  = '{1'b1, 32'h0000_0108, 32'hCAFE_F00D, 4'hF, 0, 2, 1, RESP_SLVERR, 32'h0022_0044, 1'b1, 6};
        vecs[5]  = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 0, 0, 5, RESP_SLVERR, 32'h0022_0044, 1'b1, 8};
        vecs[6]  = '{1'b0, 32'h0000_0103, 32'h0,         4'h0, 2, 0, 1, RESP_DECERR, 32'h0000_0000, 1'b1, 6};
        vecs[7]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 4'h8, 2, 2, 2, RESP_EXOKAY, 32'h0000_0000, 1'b0, 7};
        vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0,         4'h0, 1, 0, 1, RESP_EXOKAY, 32'hA500_0000, 1'b0, 5};
        vecs[9]  = '{1'b0, 32'h0000_0108, 32'h0,         4'h0, 0, 0, 1, RESP_OKAY,   32'hCAFE_F00D, 1'b0, 4};
        vecs[10] = '{1'b1, 32'h0000_0100, 32'h0000_FFFF, 4'h3, 1, 3, 1, RESP_OKAY,   32'hCAFE_F00D, 1'b0, 7};

        areset      = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;

        repeat (2) @(posedge aclk);
        #1;
        check("rst_req_ready",  req_ready, 1);
        check("rst_valids",     {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err",   resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_awaddr",     bus.awaddr, 0);
        check("rst_araddr",     bus.araddr, 0);
        check("rst_wdata",      bus.wdata, 0);
        check("rst_wstrb",      bus.wstrb, 0);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Back-to-back: each next request is presented in the previous resp_valid cycle.
        for (int i = 0; i < 11; i++)
            run_txn(vecs[i], $sformatf("v%0d", i));

        // Reset while waiting in RD_DATA: readies drop at once and the read is abandoned.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0100;
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        check("midrst_arvalid", bus.arvalid, 1);
        bus.arready = 1'b1;
        @(posedge aclk);
        #1;
        bus.arready = 1'b0;
        check("midrst_rready_before", bus.rready, 1);
        #3;
        areset = 1'b1;
        #1;
        check("midrst_rready_async", bus.rready, 0);
        check("midrst_arvalid_async", bus.arvalid, 0);
        check("midrst_req_ready", req_ready, 1);
        @(posedge aclk);
        #1;
        areset      = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h1234_5678;
        bus.rresp   = RESP_OKAY;
        pulses      = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid || bus.rready) pulses++;
            @(posedge aclk);
            #1;
        end
        bus.rvalid = 1'b0;
        check("midrst_no_resp", pulses, 0);
        check("midrst_rdata_cleared", resp_rdata, 0);
        run_txn('{1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 1, RESP_OKAY, 32'hDEAD_FFFF, 1'b0, 4}, "post_rst");

`ifdef AXIL_MASTER_TIMEOUT_EN
        // Slave never grants arready: the watchdog aborts after 16 cycles of arvalid.
        ar_hi     = 0;
        done_cyc  = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0200;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge aclk);
            #1;
            req_valid = 1'b0;
            if (resp_valid) begin
                done_cyc = cyc;
                break;
            end
            if (bus.arvalid) ar_hi++;
        end
        check("to_arvalid_cycles", ar_hi, 16);
        check("to_resp_cycle",     done_cyc, 17);
        check("to_resp_err",       resp_err, 1);
        check("to_req_ready",      req_ready, 1);
        check("to_arvalid_low",    bus.arvalid, 0);
        check("to_rdata_kept",     resp_rdata, 32'hDEAD_FFFF);
`else
        ar_hi    = 0;
        done_cyc = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
